// File: rtl/decode_stage.sv
// RV32I decode stage: small FIFO between fetch and execute, decodes the head entry
// into a registered output slot. Supports flush on redirect.
module decode_stage #(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PC_WIDTH-1:0] in_pc,
  input  logic [31:0]         in_inst,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic [6:0]          out_opcode,
  output logic [4:0]          out_rd,
  output logic [2:0]          out_funct3,
  output logic [4:0]          out_rs1,
  output logic [4:0]          out_rs2,
  output logic [6:0]          out_funct7,
  output logic                out_bit20,
  output logic                out_bit30,
  output logic [11:0]         out_csr,
  output logic [31:0]         out_imm,
  output logic                out_illegal
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  // Format immediate selected by opcode; I-type is the fallback.
  function automatic logic [31:0] decode_imm(input logic [31:0] i);
    logic [31:0] imm;
    case (i[6:0])
      OP_STORE:        imm = {{21{i[31]}}, i[30:25], i[11:7]};
      OP_JAL:          imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
      OP_LUI, OP_AUIPC: imm = {i[31:12], 12'b0};
      OP_BRANCH:       imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
      OP_SYSTEM:       imm = {27'b0, i[19:15]};
      default:         imm = {{21{i[31]}}, i[30:20]};
    endcase
    return imm;
  endfunction

  function automatic logic decode_illegal(input logic [6:0] op);
    logic ok;
    case (op)
      OP_LOAD, OP_STORE, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC,
      OP_BRANCH, OP_OP_IMM, OP_OP, OP_MISC_MEM, OP_SYSTEM: ok = 1'b1;
      default:                                             ok = 1'b0;
    endcase
    return !ok;
  endfunction

  logic [PC_WIDTH-1:0] q_pc   [DEPTH];
  logic [31:0]         q_inst [DEPTH];
  logic [PTR_W-1:0]    rd_ptr, wr_ptr;
  logic [CNT_W-1:0]    count;

  logic                push_c, load_c, pop_c, wr_en_c, q_nonempty_c;
  logic [PC_WIDTH-1:0] src_pc_c;
  logic [31:0]         src_inst_c;

  // in_ready only looks at registered count, so a pop cannot raise it in the same cycle.
  assign in_ready     = !flush && (count < CNT_W'(DEPTH));
  assign q_nonempty_c = (count != '0);
  assign push_c       = in_valid && in_ready;
  assign load_c       = (!out_valid || out_ready) && (q_nonempty_c || push_c);
  assign pop_c        = load_c && q_nonempty_c;
  assign wr_en_c      = push_c && !(load_c && !q_nonempty_c);

  always_comb begin
    src_pc_c   = in_pc;
    src_inst_c = in_inst;
    if (q_nonempty_c) begin
      src_pc_c   = q_pc[rd_ptr];
      src_inst_c = q_inst[rd_ptr];
    end
  end

  // Queue storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      q_pc[wr_ptr]   <= in_pc;
      q_inst[wr_ptr] <= in_inst;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_opcode  <= '0;
      out_rd      <= '0;
      out_funct3  <= '0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_funct7  <= '0;
      out_bit20   <= 1'b0;
      out_bit30   <= 1'b0;
      out_csr     <= '0;
      out_imm     <= '0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load_c) begin
      out_valid   <= 1'b1;
      out_pc      <= src_pc_c;
      out_opcode  <= src_inst_c[6:0];
      out_rd      <= src_inst_c[11:7];
      out_funct3  <= src_inst_c[14:12];
      out_rs1     <= src_inst_c[19:15];
      out_rs2     <= src_inst_c[24:20];
      out_funct7  <= src_inst_c[31:25];
      out_bit20   <= src_inst_c[20];
      out_bit30   <= src_inst_c[30];
      out_csr     <= src_inst_c[31:20];
      out_imm     <= decode_imm(src_inst_c);
      out_illegal <= (src_inst_c[1:0] != 2'b11) || decode_illegal(src_inst_c[6:0]);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed cases then randomized back-pressure,
// flushes and an asynchronous reset pulse, checked against a reference decoder.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_inst = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [6:0]  out_opcode;
  logic [4:0]  out_rd;
  logic [2:0]  out_funct3;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [6:0]  out_funct7;
  logic        out_bit20;
  logic        out_bit30;
  logic [11:0] out_csr;
  logic [31:0] out_imm;
  logic        out_illegal;

  decode_stage #(.DEPTH(2), .PC_WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_funct3(out_funct3),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct7(out_funct7),
    .out_bit20(out_bit20), .out_bit30(out_bit30), .out_csr(out_csr),
    .out_imm(out_imm), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } item_t;

  item_t exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference decoder written from the instruction-format rules.
  function automatic logic [31:0] ref_imm(input logic [31:0] i);
    int r;
    case (i[6:0])
      7'b0100011:             r = $signed({i[31:25], i[11:7]});
      7'b1101111:             r = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
      7'b0110111, 7'b0010111: r = int'(i & 32'hFFFF_F000);
      7'b1100011:             r = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
      7'b1110011:             r = int'((i >> 15) & 32'd31);
      default:                r = $signed(i[31:20]);
    endcase
    return 32'(r);
  endfunction

  function automatic logic ref_ill(input logic [31:0] i);
    logic [6:0] op;
    op = i[6:0];
    return (i[1:0] != 2'b11) ||
           !(op inside {7'b0000011, 7'b0100011, 7'b1101111, 7'b1100111, 7'b0110111,
                        7'b0010111, 7'b1100011, 7'b0010011, 7'b0110011, 7'b0001111,
                        7'b1110011});
  endfunction

  // Monitor: every output handshake pops one expected entry; flush then drops the rest.
  always @(negedge clk) begin
    if (resetn) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "spurious_output", 64'(out_pc), 64'(0));
        end else begin
          item_t e;
          logic [45:0] act_f, exp_f;
          e = exp_q.pop_front();
          act_f = {out_opcode, out_rd, out_funct3, out_rs1, out_rs2, out_funct7,
                   out_bit20, out_bit30, out_csr};
          exp_f = {e.inst[6:0], e.inst[11:7], e.inst[14:12], e.inst[19:15], e.inst[24:20],
                   e.inst[31:25], e.inst[20], e.inst[30], e.inst[31:20]};
          chk(out_pc == e.pc, "order_pc", 64'(out_pc), 64'(e.pc));
          chk(act_f == exp_f, "fields", 64'(act_f), 64'(exp_f));
          chk(out_imm == ref_imm(e.inst), "imm", 64'(out_imm), 64'(ref_imm(e.inst)));
          chk(out_illegal == ref_ill(e.inst), "illegal", 64'(out_illegal), 64'(ref_ill(e.inst)));
        end
      end
      if (flush) exp_q.delete();
    end
  end

  // One clock of stimulus; an accepted offer becomes an expected output.
  task automatic cycle(input bit iv, input logic [31:0] pc, input logic [31:0] inst,
                       input bit ordy, input bit fl, output bit acc);
    @(posedge clk);
    #1;
    in_valid  = iv;
    in_pc     = pc;
    in_inst   = inst;
    out_ready = ordy;
    flush     = fl;
    #1;
    acc = iv && in_ready;
    if (acc) exp_q.push_back('{pc: pc, inst: inst});
  endtask

  task automatic idle(input bit ordy);
    bit a;
    cycle(1'b0, 32'h0, 32'h0, ordy, 1'b0, a);
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) idle(1'b1);
    idle(1'b1);
    chk(exp_q.size() == 0 && !out_valid, "drain", 64'(exp_q.size()), 64'(0));
  endtask

  // Hold a single instruction in the output register and compare its immediate.
  task automatic dimm(input logic [31:0] inst, input logic [31:0] eimm, input bit eill);
    bit a;
    cycle(1'b1, 32'h200, inst, 1'b0, 1'b0, a);
    chk(a, "dimm_accept", 64'(a), 64'(1));
    idle(1'b0);
    chk(out_valid == 1'b1, "dimm_valid", 64'(out_valid), 64'(1));
    chk(out_imm == eimm, "dimm_imm", 64'(out_imm), 64'(eimm));
    chk(out_illegal == eill, "dimm_illegal", 64'(out_illegal), 64'(eill));
    idle(1'b1);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops [11] = '{7'b0000011, 7'b0100011, 7'b1101111, 7'b1100111, 7'b0110111,
                             7'b0010111, 7'b1100011, 7'b0010011, 7'b0110011, 7'b0001111,
                             7'b1110011};
    logic [31:0] r;
    int unsigned sel;
    r = $urandom();
    sel = $urandom_range(0, 13);
    if (sel < 11) r[6:0] = ops[sel];
    return r;
  endfunction

  initial begin
    bit a;
    logic [31:0] pc, inst;
    int accepted;

    #5;
    chk(out_valid == 1'b0, "reset_out_valid", 64'(out_valid), 64'(0));
    chk(out_pc == 32'h0 && out_imm == 32'h0, "reset_out_data", {out_pc, out_imm}, 64'(0));
    #8 resetn = 1'b1;
    #1;
    chk(in_ready == 1'b1, "reset_in_ready", 64'(in_ready), 64'(1));

    // Single instruction through the bypass path.
    cycle(1'b1, 32'h100, 32'h00500093, 1'b1, 1'b0, a);
    idle(1'b1);
    chk(out_valid == 1'b1, "bypass_latency", 64'(out_valid), 64'(1));
    chk(out_rd == 5'd1 && out_rs1 == 5'd0, "bypass_regs", {out_rd, out_rs1}, {5'd1, 5'd0});
    chk(out_imm == 32'h5, "bypass_imm", 64'(out_imm), 64'h5);
    chk(in_ready == 1'b1, "bypass_in_ready", 64'(in_ready), 64'(1));
    drain();

    // Fill output register plus queue, then stall and release.
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 32'h100 + 32'(4 * k), 32'h00000013 | (32'(k) << 7), 1'b0, 1'b0, a);
      chk(a, "fill_accept", 64'(a), 64'(1));
    end
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 32'h10C, 32'h00000033, 1'b0, 1'b0, a);
      chk(!a, "full_stall", 64'(a), 64'(0));
    end
    cycle(1'b1, 32'h10C, 32'h00000033, 1'b1, 1'b0, a);
    chk(!a, "full_no_comb_ready", 64'(a), 64'(0));
    a = 1'b0;
    for (int k = 0; k < 5 && !a; k++) cycle(1'b1, 32'h10C, 32'h00000033, 1'b1, 1'b0, a);
    chk(a, "full_release_accept", 64'(a), 64'(1));
    drain();

    // Immediate formats and illegal encodings.
    dimm(32'hFE112E23, 32'hFFFFFFFC, 1'b0);
    dimm(32'h8000006F, 32'hFFF00000, 1'b0);
    dimm(32'h123450B7, 32'h12345000, 1'b0);
    dimm(32'hFE000EE3, 32'hFFFFFFFC, 1'b0);
    dimm(32'h3402D073, 32'h00000005, 1'b0);
    dimm(32'h00000000, 32'h00000000, 1'b1);
    dimm(32'h0000000B, 32'h00000000, 1'b1);
    drain();

    // Flush with a full stage and a pending offer.
    for (int k = 0; k < 3; k++) cycle(1'b1, 32'h300 + 32'(4 * k), 32'h00100093, 1'b0, 1'b0, a);
    cycle(1'b1, 32'h30C, 32'h00100093, 1'b0, 1'b1, a);
    chk(!a, "flush_in_ready", 64'(a), 64'(0));
    cycle(1'b1, 32'h400, 32'h00200113, 1'b1, 1'b0, a);
    chk(out_valid == 1'b0, "flush_clears_out", 64'(out_valid), 64'(0));
    chk(a, "flush_then_accept", 64'(a), 64'(1));
    idle(1'b1);
    chk(out_valid == 1'b1 && out_pc == 32'h400, "flush_bypass_pc", 64'(out_pc), 64'h400);
    drain();

    // Random traffic with flushes and one asynchronous reset pulse.
    accepted = 0;
    pc = 32'h1000;
    inst = rand_inst();
    for (int cyc = 0; cyc < 40000 && accepted < 10000; cyc++) begin
      if (cyc == 7000) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush = 1'b0;
        #1 resetn = 1'b0;
        #1;
        chk(out_valid == 1'b0, "async_reset_out_valid", 64'(out_valid), 64'(0));
        chk(in_ready == 1'b1, "async_reset_in_ready", 64'(in_ready), 64'(1));
        exp_q.delete();
        #1 resetn = 1'b1;
      end
      cycle($urandom_range(0, 9) < 7, pc, inst, $urandom_range(0, 9) < 7,
            $urandom_range(0, 59) == 0, a);
      if (a) begin
        accepted++;
        pc = pc + 32'd4;
        inst = rand_inst();
      end
    end
    chk(accepted == 10000, "random_volume", 64'(accepted), 64'(10000));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
